// File: rtl/som_bmu_search.sv
// Best-matching-unit search: streams LANES distances per beat, keeps the
// running minimum and reports its distance/coordinate with a one-cycle pulse.
module som_bmu_search #(
  parameter int DIST_W      = 18,
  parameter int COORD_W     = 4,
  parameter int NUM_NEURONS = 16,
  parameter int LANES       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DIST_W-1:0]   in_dist,
  output logic                      busy,
  output logic                      out_valid,
  output logic [DIST_W-1:0]         winner_dist,
  output logic [COORD_W-1:0]        winner_coordinate
);
  localparam int BEATS = NUM_NEURONS / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DIST_W-1:0]    a_dist_q, a_dist_d;
  logic [COORD_W-1:0]   a_coord_q, a_coord_d;
  logic                 a_valid_q, a_valid_d;
  logic [DIST_W-1:0]    best_dist_q, best_dist_d;
  logic [COORD_W-1:0]   best_coord_q, best_coord_d;
  logic [DIST_W-1:0]    win_dist_q, win_dist_d;
  logic [COORD_W-1:0]   win_coord_q, win_coord_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 last_beat;
  logic [COORD_W-1:0]   base_coord;
  logic [DIST_W-1:0]    lane_dist [LANES];
  logic [DIST_W-1:0]    red_dist;
  logic [COORD_W-1:0]   red_coord;
  logic [DIST_W-1:0]    fin_dist;
  logic [COORD_W-1:0]   fin_coord;

  assign in_ready          = (state_q == SCAN);
  assign busy              = (state_q != IDLE);
  assign out_valid         = out_valid_q;
  assign winner_dist       = win_dist_q;
  assign winner_coordinate = win_coord_q;

  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign base_coord = COORD_W'(32'(beat_cnt_q) * LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_dist[gi] = in_dist[gi*DIST_W +: DIST_W];
  end

  // Strict less-than keeps the lower lane on ties.
  always_comb begin
    red_dist  = lane_dist[0];
    red_coord = base_coord;
    for (int l = 1; l < LANES; l++) begin
      if (lane_dist[l] < red_dist) begin
        red_dist  = lane_dist[l];
        red_coord = base_coord + COORD_W'(l);
      end
    end
  end

  // Running best with the pending stage-A entry folded in; earlier beat wins ties.
  always_comb begin
    fin_dist  = best_dist_q;
    fin_coord = best_coord_q;
    if (a_valid_q && (a_dist_q < best_dist_q)) begin
      fin_dist  = a_dist_q;
      fin_coord = a_coord_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    a_dist_d     = a_dist_q;
    a_coord_d    = a_coord_q;
    a_valid_d    = accept;
    best_dist_d  = fin_dist;
    best_coord_d = fin_coord;
    win_dist_d   = win_dist_q;
    win_coord_d  = win_coord_q;
    out_valid_d  = 1'b0;

    if (accept) begin
      a_dist_d   = red_dist;
      a_coord_d  = red_coord;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          beat_cnt_d   = '0;
          a_valid_d    = 1'b0;
          best_dist_d  = '1;
          best_coord_d = '0;
        end
      end
      SCAN: begin
        if (accept && last_beat) state_d = FLUSH;
      end
      FLUSH: begin
        state_d     = DONE;
        win_dist_d  = fin_dist;
        win_coord_d = fin_coord;
        out_valid_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      a_dist_q     <= '0;
      a_coord_q    <= '0;
      a_valid_q    <= 1'b0;
      best_dist_q  <= '1;
      best_coord_q <= '0;
      win_dist_q   <= '0;
      win_coord_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      a_dist_q     <= a_dist_d;
      a_coord_q    <= a_coord_d;
      a_valid_q    <= a_valid_d;
      best_dist_q  <= best_dist_d;
      best_coord_q <= best_coord_d;
      win_dist_q   <= win_dist_d;
      win_coord_q  <= win_coord_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_som_bmu_search.sv
// Directed bench for som_bmu_search: frames with hand-computed winners,
// checking latency, handshake, ties, back-pressure, reset abort and back-to-back.
module tb_som_bmu_search;
  localparam int DIST_W = 18;
  localparam int COORD_W = 4;
  localparam int NUM_NEURONS = 16;
  localparam int LANES = 2;
  localparam int BEATS = NUM_NEURONS / LANES;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*DIST_W-1:0] in_dist = '0;
  logic                    busy;
  logic                    out_valid;
  logic [DIST_W-1:0]       winner_dist;
  logic [COORD_W-1:0]      winner_coordinate;

  int n_checks = 0;
  int n_fail = 0;

  logic [DIST_W-1:0] frame_d [NUM_NEURONS];

  // Results captured by run_frame
  int                 acc_cnt;
  logic               timed_out;
  logic               ready_after_start;
  logic               ov_flush, rdy_flush, rdy_done, ov_done, ov_seen_scan;
  logic [DIST_W-1:0]  pre_wd, done_wd;
  logic [COORD_W-1:0] pre_wc, done_wc;

  som_bmu_search #(
    .DIST_W(DIST_W), .COORD_W(COORD_W), .NUM_NEURONS(NUM_NEURONS), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_dist(in_dist), .busy(busy), .out_valid(out_valid),
    .winner_dist(winner_dist), .winner_coordinate(winner_coordinate)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DIST_W-1:0] base, input bit ramp);
    for (int i = 0; i < NUM_NEURONS; i++)
      frame_d[i] = ramp ? base + DIST_W'(i) : base;
  endtask

  // Starts a frame from IDLE and stops at the DONE cycle sample point.
  task automatic run_frame(input bit gaps, input bit poke_start);
    int b;
    int cyc;
    b = 0;
    cyc = 0;
    acc_cnt = 0;
    ov_seen_scan = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_dist = {frame_d[1], frame_d[0]};
    tick();
    start = 1'b0;
    ready_after_start = in_ready;
    while (b < BEATS && cyc < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_dist = {frame_d[2*b+1], frame_d[2*b]};
      start = poke_start && (cyc == 2);
      if (in_valid && in_ready) begin
        b++;
        acc_cnt++;
      end
      tick();
      if (out_valid) ov_seen_scan = 1'b1;
      cyc++;
    end
    timed_out = (b < BEATS);
    start = 1'b0;
    // Junk beat outside SCAN must be ignored.
    in_valid = 1'b1;
    in_dist = '0;
    ov_flush = out_valid;
    rdy_flush = in_ready;
    pre_wd = winner_dist;
    pre_wc = winner_coordinate;
    tick();
    ov_done = out_valid;
    rdy_done = in_ready;
    done_wd = winner_dist;
    done_wc = winner_coordinate;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, busy, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/busy/ov=%b expected 000", {in_ready, busy, out_valid});
    end
    n_checks++;
    if (winner_dist !== '0 || winner_coordinate !== '0) begin
      n_fail++;
      $display("FAIL reset_winner: got %0d/%0d expected 0/0", winner_dist, winner_coordinate);
    end
    rst = 1'b1;
    tick();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    fill(18'd100, 1'b1);
    frame_d[9] = 18'd3;
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (ready_after_start !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: in_ready=%b after start expected 1", ready_after_start);
    end
    n_checks++;
    if (timed_out !== 1'b0 || acc_cnt != BEATS) begin
      n_fail++;
      $display("FAIL basic_beats: accepted %0d expected %0d", acc_cnt, BEATS);
    end
    n_checks++;
    if ({ov_seen_scan, ov_flush, ov_done} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_latency: ov scan/flush/done=%b expected 001", {ov_seen_scan, ov_flush, ov_done});
    end
    n_checks++;
    if (done_wd !== 18'd3 || done_wc !== 4'd9) begin
      n_fail++;
      $display("FAIL basic_winner: got %0d/%0d expected 3/9", done_wd, done_wc);
    end
    tick();
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_end: ov/busy/ready=%b expected 000", {out_valid, busy, in_ready});
    end
    $display("basic: winner %0d/%0d", done_wd, done_wc);
  endtask

  task automatic test_ties();
    fill(18'd500, 1'b0);
    frame_d[6] = 18'd20;
    frame_d[7] = 18'd20;
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (done_wd !== 18'd20 || done_wc !== 4'd6) begin
      n_fail++;
      $display("FAIL tie_lane: got %0d/%0d expected 20/6", done_wd, done_wc);
    end
    tick();
    $display("tie same beat: winner %0d/%0d", done_wd, done_wc);
    fill(18'd500, 1'b0);
    frame_d[4] = 18'd50;
    frame_d[11] = 18'd50;
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (done_wd !== 18'd50 || done_wc !== 4'd4) begin
      n_fail++;
      $display("FAIL tie_beat: got %0d/%0d expected 50/4", done_wd, done_wc);
    end
    tick();
    $display("tie across beats: winner %0d/%0d", done_wd, done_wc);
  endtask

  task automatic test_backpressure();
    fill(18'd100, 1'b1);
    frame_d[9] = 18'd3;
    run_frame(1'b1, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (timed_out !== 1'b0 || acc_cnt != BEATS) begin
      n_fail++;
      $display("FAIL bp_beats: accepted %0d expected %0d", acc_cnt, BEATS);
    end
    n_checks++;
    if ({rdy_flush, rdy_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_ready: in_ready flush/done=%b expected 00", {rdy_flush, rdy_done});
    end
    n_checks++;
    if (ov_done !== 1'b1 || done_wd !== 18'd3 || done_wc !== 4'd9) begin
      n_fail++;
      $display("FAIL bp_winner: ov=%b got %0d/%0d expected 1 3/9", ov_done, done_wd, done_wc);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle_ready: in_ready=%b expected 0", in_ready);
    end
    $display("backpressure: %0d beats, winner %0d/%0d", acc_cnt, done_wd, done_wc);
  endtask

  task automatic test_all_ones();
    fill(18'h3FFFF, 1'b0);
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (done_wd !== 18'h3FFFF || done_wc !== 4'd0) begin
      n_fail++;
      $display("FAIL all_ones: got %h/%0d expected 3ffff/0", done_wd, done_wc);
    end
    tick();
    $display("all ones: winner %h/%0d", done_wd, done_wc);
  endtask

  task automatic test_reset_mid_frame();
    logic ov_any;
    fill(18'd300, 1'b0);
    frame_d[1] = 18'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_dist = {frame_d[2*i+1], frame_d[2*i]};
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || winner_dist !== '0 || winner_coordinate !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy/ready/ov=%b win=%0d/%0d expected 000 0/0",
               {busy, in_ready, out_valid}, winner_dist, winner_coordinate);
    end
    rst = 1'b1;
    ov_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid || busy) ov_any = 1'b1;
    end
    n_checks++;
    if (ov_any !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet: out_valid/busy seen=%b expected 0", ov_any);
    end
    fill(18'd300, 1'b0);
    frame_d[2] = 18'd7;
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (ov_done !== 1'b1 || done_wd !== 18'd7 || done_wc !== 4'd2) begin
      n_fail++;
      $display("FAIL midreset_next: ov=%b got %0d/%0d expected 1 7/2", ov_done, done_wd, done_wc);
    end
    tick();
    $display("reset mid-frame: next winner %0d/%0d", done_wd, done_wc);
  endtask

  task automatic test_back_to_back();
    fill(18'd100, 1'b1);
    frame_d[9] = 18'd3;
    run_frame(1'b0, 1'b1);
    n_checks++;
    if (ov_done !== 1'b1 || done_wd !== 18'd3 || done_wc !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_first: ov=%b got %0d/%0d expected 1 3/9", ov_done, done_wd, done_wc);
    end
    // start during DONE must be ignored.
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_done_start: busy/ov=%b expected 00", {busy, out_valid});
    end
    fill(18'd200, 1'b0);
    frame_d[15] = 18'd12;
    run_frame(1'b0, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (ready_after_start !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_start: in_ready=%b expected 1", ready_after_start);
    end
    n_checks++;
    if (pre_wd !== 18'd3 || pre_wc !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d/%0d expected 3/9", pre_wd, pre_wc);
    end
    n_checks++;
    if (ov_done !== 1'b1 || done_wd !== 18'd12 || done_wc !== 4'd15) begin
      n_fail++;
      $display("FAIL b2b_second: ov=%b got %0d/%0d expected 1 12/15", ov_done, done_wd, done_wc);
    end
    tick();
    n_checks++;
    if (winner_dist !== 18'd12 || winner_coordinate !== 4'd15 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after: ov=%b got %0d/%0d expected 0 12/15", out_valid, winner_dist, winner_coordinate);
    end
    $display("back-to-back: winners 3/9 then %0d/%0d", done_wd, done_wc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_all_ones();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
